// File: rtl/cpu_state_controller.sv
// Instruction life-cycle sequencer: drives the state bus, issues unit requests,
// folds all trap sources into one TRAP state and counts retired instructions.
module cpu_state_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fetch_over,
  input  logic [31:0] i_instruction,
  input  logic        i_mem_done,
  input  logic        i_muldiv_done,
  input  logic        i_bus_error,
  input  logic        i_irq,
  input  logic        i_irq_enable,
  output logic [31:0] state,
  output logic        o_fetch_req,
  output logic        o_mem_req,
  output logic        o_muldiv_start,
  output logic        o_retire,
  output logic        o_trap,
  output logic [31:0] o_trap_cause,
  output logic [63:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXECUTE = 3'd1,
    S_MULDIV  = 3'd2,
    S_MEMORY  = 3'd3,
    S_WFI     = 3'd5,
    S_TRAP    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] code_q, code_d;
  logic [31:0] cause_q, cause_d;
  logic [63:0] instret_q, instret_d;
  logic        retire_q, retire_d;
  logic        mem_req_q, mem_req_d;
  logic        md_start_q, md_start_d;
  logic        retire_now;
  logic        tmo_hit;
  logic [31:0] mem_cause;

  // Counter equals the number of completed cycles in the current state.
  assign tmo_hit   = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
  assign mem_cause = (code_q <= 32'd31) ? 32'd5 : 32'd7;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cause_d    = cause_q;
    instret_d  = instret_q;
    retire_d   = 1'b0;
    mem_req_d  = 1'b0;
    md_start_d = 1'b0;
    retire_now = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (i_fetch_over) begin
          state_d = S_EXECUTE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 32'd1;
        end
      end
      S_EXECUTE: begin
        code_d = i_instruction;
        if (i_instruction >= 32'd10 && i_instruction <= 32'd17) begin
          state_d    = S_MULDIV;
          md_start_d = 1'b1;
        end else if (i_instruction >= 32'd27 && i_instruction <= 32'd34) begin
          state_d   = S_MEMORY;
          mem_req_d = 1'b1;
        end else if (i_instruction == 32'd58) begin
          state_d = S_WFI;
        end else if (i_instruction == 32'd255) begin
          state_d = S_TRAP;
          cause_d = 32'd2;
        end else if (i_instruction == 32'd53) begin
          state_d = S_TRAP;
          cause_d = 32'd11;
        end else if (i_instruction == 32'd54) begin
          state_d = S_TRAP;
          cause_d = 32'd3;
        end else begin
          retire_now = 1'b1;
        end
      end
      S_MULDIV: begin
        if (i_muldiv_done) begin
          retire_now = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 32'd2;
        end
      end
      S_MEMORY: begin
        if (i_bus_error) begin
          state_d = S_TRAP;
          cause_d = mem_cause;
        end else if (i_mem_done) begin
          retire_now = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = mem_cause;
        end
      end
      S_WFI: begin
        if (i_irq) retire_now = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (retire_now) begin
      retire_d  = 1'b1;
      instret_d = instret_q + 64'd1;
      if (i_irq && i_irq_enable) begin
        state_d = S_TRAP;
        cause_d = 32'h8000_000B;
      end else begin
        state_d = S_FETCH;
      end
    end

    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == S_FETCH || state_q == S_MULDIV || state_q == S_MEMORY) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      tmo_q      <= '0;
      code_q     <= '0;
      cause_q    <= '0;
      instret_q  <= '0;
      retire_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      code_q     <= code_d;
      cause_q    <= cause_d;
      instret_q  <= instret_d;
      retire_q   <= retire_d;
      mem_req_q  <= mem_req_d;
      md_start_q <= md_start_d;
    end
  end

  assign state          = {29'd0, state_q};
  assign o_fetch_req    = (state_q == S_FETCH);
  assign o_trap         = (state_q == S_TRAP);
  assign o_mem_req      = mem_req_q;
  assign o_muldiv_start = md_start_q;
  assign o_retire       = retire_q;
  assign o_trap_cause   = cause_q;
  assign o_instret      = instret_q;

endmodule

// File: tb/tb_cpu_state_controller.sv
// Self-checking bench: transaction-level model predicts the state/pulse sequence of each instruction.
module tb_cpu_state_controller;
  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset, fo, mdd, md, be, irq, ien;
  logic [31:0] instr;
  logic [31:0] state, o_trap_cause;
  logic        o_fetch_req, o_mem_req, o_muldiv_start, o_retire, o_trap;
  logic [63:0] o_instret;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_instret;
  logic [31:0] exp_cause;

  always #5 clk = ~clk;

  cpu_state_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .i_fetch_over(fo), .i_instruction(instr),
    .i_mem_done(md), .i_muldiv_done(mdd), .i_bus_error(be), .i_irq(irq),
    .i_irq_enable(ien), .state(state), .o_fetch_req(o_fetch_req),
    .o_mem_req(o_mem_req), .o_muldiv_start(o_muldiv_start), .o_retire(o_retire),
    .o_trap(o_trap), .o_trap_cause(o_trap_cause), .o_instret(o_instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fo = 1'b0; mdd = 1'b0; md = 1'b0; be = 1'b0; irq = 1'b0;
  endtask

  task automatic expect_cyc(input int st, input bit ret, input bit ms, input bit mr);
    check("state", 64'(state), 64'(st));
    check("fetch_req", 64'(o_fetch_req), 64'(st == 0));
    check("trap", 64'(o_trap), 64'(st == 6));
    check("retire", 64'(o_retire), 64'(ret));
    check("muldiv_start", 64'(o_muldiv_start), 64'(ms));
    check("mem_req", 64'(o_mem_req), 64'(mr));
    check("trap_cause", 64'(o_trap_cause), 64'(exp_cause));
    check("instret", o_instret, exp_instret);
  endtask

  task automatic trap_seq(input logic [31:0] c);
    step();
    exp_cause = c;
    expect_cyc(6, 1'b0, 1'b0, 1'b0);
    idle_inputs();
    step();
    expect_cyc(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic retire_seq(input bit tr);
    step();
    exp_instret = exp_instret + 64'd1;
    if (tr) exp_cause = 32'h8000_000B;
    expect_cyc(tr ? 6 : 0, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    if (tr) begin
      step();
      expect_cyc(0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Entered at a negedge in the first FETCH cycle; returns the same way.
  task automatic do_instr(input int code, input int fwait, input int dwait,
                          input bit err, input bit done, input bit irqb);
    for (int k = 0; k != fwait; k++) begin
      fo = 1'b0; irq = 1'($urandom_range(0, 1));
      if (k == int'(T) - 1) begin trap_seq(32'd1); return; end
      step();
      expect_cyc(0, 1'b0, 1'b0, 1'b0);
    end
    idle_inputs();
    fo = 1'b1; instr = 32'(code);
    step();
    fo = 1'b0;
    expect_cyc(1, 1'b0, 1'b0, 1'b0);

    if (code >= 10 && code <= 17) begin
      step();
      expect_cyc(2, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k != dwait; k++) begin
        mdd = 1'b0; irq = 1'($urandom_range(0, 1)); fo = 1'($urandom_range(0, 1));
        if (k == int'(T) - 1) begin trap_seq(32'd2); return; end
        step();
        expect_cyc(2, 1'b0, 1'b0, 1'b0);
      end
      mdd = 1'b1; irq = irqb;
      retire_seq(irqb & ien);
    end else if (code >= 27 && code <= 34) begin
      logic [31:0] mc;
      mc = (code <= 31) ? 32'd5 : 32'd7;
      step();
      expect_cyc(3, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k != dwait; k++) begin
        md = 1'b0; be = 1'b0; irq = 1'($urandom_range(0, 1)); fo = 1'($urandom_range(0, 1));
        if (k == int'(T) - 1) begin trap_seq(mc); return; end
        step();
        expect_cyc(3, 1'b0, 1'b0, 1'b0);
      end
      be = err; md = err ? done : 1'b1; irq = irqb;
      if (err) trap_seq(mc);
      else     retire_seq(irqb & ien);
    end else if (code == 58) begin
      step();
      expect_cyc(5, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < dwait; k++) begin
        irq = 1'b0; fo = 1'($urandom_range(0, 1));
        step();
        expect_cyc(5, 1'b0, 1'b0, 1'b0);
      end
      irq = 1'b1;
      retire_seq(ien);
    end else if (code == 255 || code == 53 || code == 54) begin
      irq = 1'($urandom_range(0, 1));
      trap_seq(code == 255 ? 32'd2 : (code == 53 ? 32'd11 : 32'd3));
    end else begin
      irq = irqb;
      retire_seq(irqb & ien);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int code;
    reset = 1'b1; idle_inputs(); instr = '0; ien = 1'b0;
    exp_instret = '0; exp_cause = '0;
    step(); step();
    expect_cyc(0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    do_instr(18, 2, 0, 1'b0, 1'b0, 1'b0);   // ADDI after two idle FETCH cycles
    do_instr(10, 0, 5, 1'b0, 1'b0, 1'b0);   // MUL
    do_instr(29, 0, 2, 1'b1, 1'b1, 1'b0);   // LW, error and done together
    do_instr(255, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(53, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(54, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(18, 8, 0, 1'b0, 1'b0, 1'b0);   // FETCH timeout
    do_instr(18, 7, 0, 1'b0, 1'b0, 1'b0);   // fetch_over on the last allowed cycle
    do_instr(12, 0, 8, 1'b0, 1'b0, 1'b0);   // MULDIV timeout
    do_instr(13, 0, 7, 1'b0, 1'b0, 1'b0);
    do_instr(33, 0, 8, 1'b0, 1'b0, 1'b0);   // MEMORY timeout, store class
    do_instr(33, 0, 1, 1'b1, 1'b0, 1'b0);
    ien = 1'b1;
    do_instr(58, 0, 20, 1'b0, 1'b0, 1'b0);  // WFI woken by interrupt
    do_instr(20, 0, 0, 1'b0, 1'b0, 1'b1);   // interrupt at single-cycle retire
    ien = 1'b0;

    // Reset while waiting in MEMORY, completion input present in the same cycle.
    fo = 1'b1; instr = 32'd30;
    step(); fo = 1'b0;
    expect_cyc(1, 1'b0, 1'b0, 1'b0);
    step();
    expect_cyc(3, 1'b0, 1'b0, 1'b1);
    step();
    reset = 1'b1; md = 1'b1;
    step();
    exp_instret = '0; exp_cause = '0;
    expect_cyc(0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; idle_inputs();

    // Counter wrap: preload all-ones, then retire one instruction.
    force dut.instret_q = '1;
    step();
    release dut.instret_q;
    exp_instret = '1;
    expect_cyc(0, 1'b0, 1'b0, 1'b0);
    do_instr(18, 0, 0, 1'b0, 1'b0, 1'b0);
    check("instret_wrap", o_instret, 64'd0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 6))
        0:       code = int'($urandom_range(10, 17));
        1:       code = int'($urandom_range(27, 34));
        2:       code = 58;
        3: begin
          case ($urandom_range(0, 2))
            0:       code = 255;
            1:       code = 53;
            default: code = 54;
          endcase
        end
        default: code = int'($urandom_range(0, 59));
      endcase
      ien = 1'($urandom_range(0, 1));
      do_instr(code, int'($urandom_range(0, 8)),
               (code == 58) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 8)),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
